fifo_read_logic: RTL and testbench

Read-domain pointer and flag logic for the dual-clock FIFO. It is the counterpart of the write-side pointer logic. It accepts read requests from the consumer, advances a binary and Gray read pointer, and drives the storage-array read address and read strobe. It derives `rempty`, a fill level and an almost-empty flag from the write pointer, which is already Gray-coded and synchronised into the read clock domain. It also tracks a sticky underflow flag and a small occupancy FSM.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_read_logic_gray2bin.sv | 16 +
 rtl/fifo_read_logic.sv | 97 +++++++++
 tb/tb_fifo_read_logic.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Definitions shared by the read- and write-side pointer logic of the dual-clock FIFO.
package fifo_pkg;

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] READ  = 2'b01;
   localparam logic [1:0] EMPTY = 2'b10;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return (b >> 1) ^ b;
   endfunction

   // Only the low w bits of g are meaningful; upper result bits are zero.
   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
      logic [31:0] b;
      b = '0;
      for (int unsigned i = 0; i < w; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_read_logic_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
   parameter int unsigned W = 3
) (
   input  logic [W-1:0] gray_i,
   output logic [W-1:0] bin_o
);

   always_comb begin
      bin_o = '0;
      for (int unsigned i = 0; i < W; i++) begin
         bin_o[i] = ^(gray_i >> i);
      end
   end

endmodule

// File: rtl/fifo_read_logic.sv
// Read-domain pointer, empty/level flags, underflow tracking and occupancy FSM of the dual-clock FIFO.
module fifo_read_logic
   import fifo_pkg::IDLE, fifo_pkg::READ, fifo_pkg::EMPTY;
#(
   parameter int unsigned PTR_SZ    = 2,
   parameter int unsigned AE_THRESH = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rinc,
   input  logic [PTR_SZ:0]   wq2_waddr,
   output logic              rempty,
   output logic              read_en,
   output logic [PTR_SZ-1:0] raddr,
   output logic [PTR_SZ:0]   raddr_gray,
   output logic              rvalid,
   output logic [PTR_SZ:0]   rlevel,
   output logic              ralmost_empty,
   output logic              rerr,
   output logic [1:0]        rstate
);

   localparam logic [PTR_SZ:0] AE_LVL = AE_THRESH[PTR_SZ:0];

   logic [PTR_SZ:0] rbin_q, rbin_d;
   logic [PTR_SZ:0] rgray_q, rgray_d;
   logic [PTR_SZ:0] rlevel_q, rlevel_d;
   logic [PTR_SZ:0] wbin;
   logic            rempty_q, rempty_d;
   logic            rae_q, rae_d;
   logic            rvalid_q;
   logic            rerr_q, rerr_d;
   logic [1:0]      state_q, state_d;

   gray2bin #(.W(PTR_SZ + 1)) u_wptr_g2b (
      .gray_i (wq2_waddr),
      .bin_o  (wbin)
   );

   assign read_en = rinc && !rempty_q;

   // Empty and level look at the post-increment pointer so a read of the
   // last word and a same-cycle write are both reflected at this edge.
   always_comb begin
      rbin_d   = rbin_q + {{PTR_SZ{1'b0}}, read_en};
      rgray_d  = (rbin_d >> 1) ^ rbin_d;
      rempty_d = (rgray_d == wq2_waddr);
      rlevel_d = wbin - rbin_d;
      rae_d    = (rlevel_d <= AE_LVL);
      rerr_d   = rerr_q || (rinc && rempty_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rbin_q   <= '0;
         rgray_q  <= '0;
         rempty_q <= 1'b1;
         rvalid_q <= 1'b0;
         rlevel_q <= '0;
         rae_q    <= 1'b1;
         rerr_q   <= 1'b0;
      end else begin
         rbin_q   <= rbin_d;
         rgray_q  <= rgray_d;
         rempty_q <= rempty_d;
         rvalid_q <= read_en;
         rlevel_q <= rlevel_d;
         rae_q    <= rae_d;
         rerr_q   <= rerr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!rempty_q) state_d = READ;
         READ:    if (rempty_q)  state_d = EMPTY;
         EMPTY:   if (!rempty_q) state_d = READ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   assign rempty        = rempty_q;
   assign raddr         = rbin_q[PTR_SZ-1:0];
   assign raddr_gray    = rgray_q;
   assign rvalid        = rvalid_q;
   assign rlevel        = rlevel_q;
   assign ralmost_empty = rae_q;
   assign rerr          = rerr_q;
   assign rstate        = state_q;

endmodule

// File: tb/tb_fifo_read_logic.sv
// Directed bench for fifo_read_logic with PTR_SZ=2, AE_THRESH=1.
module tb_fifo_read_logic;

   logic       clk;
   logic       rst;
   logic       rinc;
   logic [2:0] wq2_waddr;
   logic       rempty;
   logic       read_en;
   logic [1:0] raddr;
   logic [2:0] raddr_gray;
   logic       rvalid;
   logic [2:0] rlevel;
   logic       ralmost_empty;
   logic       rerr;
   logic [1:0] rstate;

   int n_chk;
   int n_fail;

   fifo_read_logic #(.PTR_SZ(2), .AE_THRESH(1)) dut (
      .clk           (clk),
      .rst           (rst),
      .rinc          (rinc),
      .wq2_waddr     (wq2_waddr),
      .rempty        (rempty),
      .read_en       (read_en),
      .raddr         (raddr),
      .raddr_gray    (raddr_gray),
      .rvalid        (rvalid),
      .rlevel        (rlevel),
      .ralmost_empty (ralmost_empty),
      .rerr          (rerr),
      .rstate        (rstate)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_ptr(input string tag, input logic [1:0] a, input logic [2:0] g,
                          input logic [2:0] lvl, input logic emp);
      chk({tag, ".raddr"},      32'(raddr),      32'(a));
      chk({tag, ".raddr_gray"}, 32'(raddr_gray), 32'(g));
      chk({tag, ".rlevel"},     32'(rlevel),     32'(lvl));
      chk({tag, ".rempty"},     32'(rempty),     32'(emp));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      rinc      = 1'b0;
      wq2_waddr = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      chk_ptr("rst0", 2'd0, 3'b000, 3'd0, 1'b1);
      chk("rst0.ae",     32'(ralmost_empty), 32'd1);
      chk("rst0.rerr",   32'(rerr),          32'd0);
      chk("rst0.rstate", 32'(rstate),        32'd0);
      chk("rst0.rvalid", 32'(rvalid),        32'd0);
      chk("rst0.rd_en",  32'(read_en),       32'd0);

      // single word
      rst       = 1'b0;
      wq2_waddr = 3'b001;
      step();
      chk_ptr("sw.arrive", 2'd0, 3'b000, 3'd1, 1'b0);
      chk("sw.ae",     32'(ralmost_empty), 32'd1);
      chk("sw.state0", 32'(rstate),        32'd0);
      step();
      chk("sw.state1", 32'(rstate),        32'd1);
      rinc = 1'b1;
      #1;
      chk("sw.rd_en",  32'(read_en),       32'd1);
      step();
      rinc = 1'b0;
      chk_ptr("sw.read", 2'd1, 3'b001, 3'd0, 1'b1);
      chk("sw.rvalid1", 32'(rvalid),       32'd1);
      chk("sw.state2",  32'(rstate),       32'd1);
      step();
      chk("sw.rvalid0", 32'(rvalid),       32'd0);
      chk("sw.state3",  32'(rstate),       32'd2);

      // underflow
      rinc = 1'b1;
      #1;
      chk("uf.rd_en", 32'(read_en), 32'd0);
      step();
      rinc = 1'b0;
      chk_ptr("uf.hold", 2'd1, 3'b001, 3'd0, 1'b1);
      chk("uf.rerr",   32'(rerr),   32'd1);
      chk("uf.rvalid", 32'(rvalid), 32'd0);
      wq2_waddr = 3'b011;
      step();
      chk_ptr("uf.data", 2'd1, 3'b001, 3'd1, 1'b0);
      chk("uf.sticky", 32'(rerr), 32'd1);

      // asynchronous reset mid-stream
      #2;
      rst       = 1'b1;
      wq2_waddr = 3'b000;
      #1;
      chk_ptr("rst1", 2'd0, 3'b000, 3'd0, 1'b1);
      chk("rst1.ae",     32'(ralmost_empty), 32'd1);
      chk("rst1.rerr",   32'(rerr),          32'd0);
      chk("rst1.rstate", 32'(rstate),        32'd0);
      step();
      rst = 1'b0;

      // full drain
      wq2_waddr = 3'b110;
      step();
      chk_ptr("fd.fill", 2'd0, 3'b000, 3'd4, 1'b0);
      chk("fd.ae0", 32'(ralmost_empty), 32'd0);
      rinc = 1'b1;
      step();
      chk_ptr("fd.r1", 2'd1, 3'b001, 3'd3, 1'b0);
      step();
      chk_ptr("fd.r2", 2'd2, 3'b011, 3'd2, 1'b0);
      chk("fd.ae2", 32'(ralmost_empty), 32'd0);
      step();
      chk_ptr("fd.r3", 2'd3, 3'b010, 3'd1, 1'b0);
      chk("fd.ae3", 32'(ralmost_empty), 32'd1);
      step();
      rinc = 1'b0;
      chk_ptr("fd.r4", 2'd0, 3'b110, 3'd0, 1'b1);
      chk("fd.rvalid", 32'(rvalid), 32'd1);

      // wrap
      wq2_waddr = 3'b000;
      step();
      chk_ptr("wr.fill", 2'd0, 3'b110, 3'd4, 1'b0);
      rinc = 1'b1;
      step();
      chk_ptr("wr.r5", 2'd1, 3'b111, 3'd3, 1'b0);
      step();
      chk_ptr("wr.r6", 2'd2, 3'b101, 3'd2, 1'b0);
      step();
      chk_ptr("wr.r7", 2'd3, 3'b100, 3'd1, 1'b0);
      rinc      = 1'b0;
      wq2_waddr = 3'b001;
      step();
      chk_ptr("wr.lvl", 2'd3, 3'b100, 3'd2, 1'b0);
      rinc = 1'b1;
      step();
      chk_ptr("wr.r0", 2'd0, 3'b000, 3'd1, 1'b0);

      // read and write in the same cycle with one word left
      wq2_waddr = 3'b011;
      step();
      rinc = 1'b0;
      chk_ptr("sim", 2'd1, 3'b001, 3'd1, 1'b0);
      chk("sim.rerr", 32'(rerr), 32'd0);
      step();
      chk("sim.state", 32'(rstate), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
